// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: state encoding and line-geometry helpers shared by the I-cache refill controller.
// I_INDEX_WIDTH / I_WO_WIDTH normally come from cache.h; the fallbacks below keep a standalone build usable.
`ifndef I_INDEX_WIDTH
`define I_INDEX_WIDTH 6
`endif
`ifndef I_WO_WIDTH
`define I_WO_WIDTH 2
`endif
package icache_refill_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2, DONE = 2'd3} state_t;
    function automatic int words(input int wow);
        return 1 << wow;
    endfunction
    function automatic int line_aw(input int tw, input int iw, input int wow);
        return tw + iw + wow;
    endfunction
endpackage

// File: rtl/icache_refill_ctr.sv
// icache_refill_ctr: wrapping word-offset counter plus beat counter flagging the last beat of a line.
module icache_refill_ctr
    import icache_refill_pkg::*;
#(
    parameter int WOW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [WOW-1:0] start,
    input  logic           adv,
    output logic [WOW-1:0] offset,
    output logic           last
);
    logic [WOW-1:0] beats;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset <= '0;
            beats  <= '0;
        end else if (load) begin
            offset <= start;
            beats  <= '0;
        end else if (adv) begin
            offset <= offset + 1'b1;
            beats  <= beats + 1'b1;
        end
    end
    assign last = beats == WOW'(words(WOW) - 1);
endmodule

// File: rtl/icache_refill.sv
// icache_refill: fetches a missed I-cache line word by word into the victim way, then installs its tag.
// Optional ICACHE_CRIT_WORD_FIRST_EN: refill starts at the missed word offset and wraps around the line.
`ifndef I_INDEX_WIDTH
`define I_INDEX_WIDTH 6
`endif
`ifndef I_WO_WIDTH
`define I_WO_WIDTH 2
`endif
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int DW  = 32,
    parameter int TW  = 20,
    parameter int IW  = `I_INDEX_WIDTH,
    parameter int WOW = `I_WO_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_valid,
    output logic                           miss_ready,
    input  logic [TW-1:0]                  miss_tag,
    input  logic [IW-1:0]                  miss_index,
    input  logic [WOW-1:0]                 miss_offset,
    input  logic [1:0]                     miss_way,
    output logic                           mem_req,
    output logic [line_aw(TW,IW,WOW)-1:0]  mem_addr,
    input  logic                           mem_ack,
    input  logic                           mem_rvalid,
    input  logic [DW-1:0]                  mem_rdata,
    output logic [IW-1:0]                  ram_index,
    output logic [1:0]                     ram_way,
    output logic [WOW-1:0]                 ram_offset,
    output logic [DW-1:0]                  ram_din,
    output logic                           ram_we,
    output logic                           ram_en,
    output logic                           tag_we,
    output logic                           tag_valid,
    output logic [TW-1:0]                  tag_out,
    output logic                           refill_done,
    output logic                           busy
);
`ifdef ICACHE_CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif
    state_t         state, nxt;
    logic [TW-1:0]  tag_q;
    logic [IW-1:0]  index_q;
    logic [1:0]     way_q;
    logic [WOW-1:0] off_q, start, offset;
    logic           load, adv, last;
    assign start = CWF ? off_q : '0;
    assign busy  = state != IDLE;
    icache_refill_ctr #(.WOW(WOW)) u_ctr (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .start  (start),
        .adv    (adv),
        .offset (offset),
        .last   (last)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tag_q   <= '0;
            index_q <= '0;
            way_q   <= '0;
            off_q   <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && miss_valid) begin
                tag_q   <= miss_tag;
                index_q <= miss_index;
                way_q   <= miss_way;
                off_q   <= miss_offset;
            end
        end
    end
    // The victim is invalidated at accept so partially written lines can never hit.
    always_comb begin
        nxt         = state;
        miss_ready  = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        ram_index   = '0;
        ram_way     = '0;
        ram_offset  = '0;
        ram_din     = '0;
        ram_we      = 1'b0;
        ram_en      = 1'b0;
        tag_we      = 1'b0;
        tag_valid   = 1'b0;
        tag_out     = '0;
        refill_done = 1'b0;
        load        = 1'b0;
        adv         = 1'b0;
        case (state)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    nxt       = REQ;
                    tag_we    = 1'b1;
                    ram_index = miss_index;
                    ram_way   = miss_way;
                end
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q, index_q, start};
                load     = mem_ack;
                nxt      = mem_ack ? FILL : REQ;
            end
            FILL: begin
                ram_index  = index_q;
                ram_way    = way_q;
                ram_offset = offset;
                ram_din    = mem_rdata;
                ram_we     = mem_rvalid;
                ram_en     = mem_rvalid;
                adv        = mem_rvalid;
                nxt        = (mem_rvalid && last) ? DONE : FILL;
            end
            DONE: begin
                ram_index   = index_q;
                ram_way     = way_q;
                tag_we      = 1'b1;
                tag_valid   = 1'b1;
                tag_out     = tag_q;
                refill_done = 1'b1;
                nxt         = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed scenarios for icache_refill; expected offsets track ICACHE_CRIT_WORD_FIRST_EN.
`ifndef I_INDEX_WIDTH
`define I_INDEX_WIDTH 6
`endif
`ifndef I_WO_WIDTH
`define I_WO_WIDTH 2
`endif
module tb_icache_refill;
    localparam int DW = 32, TW = 20, IW = `I_INDEX_WIDTH, WOW = `I_WO_WIDTH;
    localparam int AW = TW + IW + WOW;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif
    logic clk = 1'b0, rst;
    logic miss_valid, miss_ready, mem_req, mem_ack, mem_rvalid;
    logic [TW-1:0] miss_tag, tag_out;
    logic [IW-1:0] miss_index, ram_index;
    logic [WOW-1:0] miss_offset, ram_offset;
    logic [1:0] miss_way, ram_way;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata, ram_din;
    logic ram_we, ram_en, tag_we, tag_valid, refill_done, busy;
    int n_cmp = 0, n_err = 0, valid_writes = 0;

    icache_refill dut (
        .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_tag(miss_tag), .miss_index(miss_index), .miss_offset(miss_offset), .miss_way(miss_way),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .ram_index(ram_index), .ram_way(ram_way), .ram_offset(ram_offset),
        .ram_din(ram_din), .ram_we(ram_we), .ram_en(ram_en), .tag_we(tag_we), .tag_valid(tag_valid),
        .tag_out(tag_out), .refill_done(refill_done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (tag_we === 1'b1 && tag_valid === 1'b1) valid_writes <= valid_writes + 1;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({miss_ready, busy, mem_req, ram_we, ram_en, tag_we, tag_valid, refill_done} !== 8'b1000_0000) begin
            n_err++;
            $display("FAIL reset_flags got %b want 10000000",
                     {miss_ready, busy, mem_req, ram_we, ram_en, tag_we, tag_valid, refill_done});
        end
        n_cmp++;
        if ({mem_addr, ram_index, ram_way, ram_offset, ram_din, tag_out} !== '0) begin
            n_err++;
            $display("FAIL reset_buses got addr=%h idx=%h way=%h off=%h din=%h tag=%h want all 0",
                     mem_addr, ram_index, ram_way, ram_offset, ram_din, tag_out);
        end
    endtask

    // Full refill from the accept cycle through the following IDLE cycle; starts and ends at posedge+1.
    task automatic run_refill(input string nm, input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                              input logic [1:0] way, input logic [WOW-1:0] off, input int ack_wait,
                              input logic [15:0] pat, input int plen, input bit early, input bit hold);
        logic [WOW-1:0] eo;
        logic [AW-1:0] ea;
        logic [DW-1:0] data;
        int beats;
        eo = CWF ? off : '0;
        ea = {tag, idx, eo};
        beats = 0;
        miss_tag = tag; miss_index = idx; miss_way = way; miss_offset = off;
        miss_valid = 1'b1; mem_ack = 1'b0; mem_rvalid = 1'b0;
        #1;
        n_cmp++;
        if ({miss_ready, busy, tag_we, tag_valid, ram_index, ram_way} !== {4'b1010, idx, way}) begin
            n_err++;
            $display("FAIL %s_accept got rdy/busy/twe/tv=%b idx=%h way=%h want 1010 idx=%h way=%h",
                     nm, {miss_ready, busy, tag_we, tag_valid}, ram_index, ram_way, idx, way);
        end
        cyc();
        miss_valid = hold;
        for (int i = 0; i <= ack_wait; i++) begin
            mem_ack = (i == ack_wait);
            mem_rvalid = early;
            mem_rdata = 32'hDEAD_BEEF;
            #1;
            n_cmp++;
            if ({mem_req, busy, miss_ready, ram_we, tag_we} !== 5'b11000 || mem_addr !== ea) begin
                n_err++;
                $display("FAIL %s_req%0d got req/busy/rdy/we/twe=%b addr=%h want 11000 addr=%h",
                         nm, i, {mem_req, busy, miss_ready, ram_we, tag_we}, mem_addr, ea);
            end
            cyc();
        end
        mem_ack = 1'b0;
        for (int i = 0; i < plen; i++) begin
            data = 32'hA000_0000 | (32'(idx) << 8) | 32'(beats);
            mem_rvalid = pat[i];
            mem_rdata = data;
            #1;
            n_cmp++;
            if ({ram_we, ram_en, tag_we, refill_done, busy} !== {pat[i], pat[i], 3'b001}) begin
                n_err++;
                $display("FAIL %s_fill%0d got we/en/twe/done/busy=%b want %b", nm, i,
                         {ram_we, ram_en, tag_we, refill_done, busy}, {pat[i], pat[i], 3'b001});
            end
            if (pat[i]) begin
                n_cmp++;
                if ({ram_index, ram_way, ram_offset, ram_din} !== {idx, way, eo, data}) begin
                    n_err++;
                    $display("FAIL %s_word%0d got idx=%h way=%h off=%h din=%h want idx=%h way=%h off=%h din=%h",
                             nm, beats, ram_index, ram_way, ram_offset, ram_din, idx, way, eo, data);
                end
                eo = eo + 1'b1;
                beats++;
            end
            cyc();
        end
        mem_rvalid = 1'b1;
        #1;
        n_cmp++;
        if ({tag_we, tag_valid, refill_done, ram_we, busy} !== 5'b11101 || tag_out !== tag ||
            {ram_index, ram_way} !== {idx, way}) begin
            n_err++;
            $display("FAIL %s_done got twe/tv/done/we/busy=%b tag=%h idx=%h way=%h want 11101 tag=%h idx=%h way=%h",
                     nm, {tag_we, tag_valid, refill_done, ram_we, busy}, tag_out, ram_index, ram_way, tag, idx, way);
        end
        cyc();
        mem_rvalid = 1'b0;
        #1;
        n_cmp++;
        if ({busy, miss_ready, refill_done, tag_valid, tag_we} !== {4'b0100, hold}) begin
            n_err++;
            $display("FAIL %s_idle got busy/rdy/done/tv/twe=%b want %b", nm,
                     {busy, miss_ready, refill_done, tag_valid, tag_we}, {4'b0100, hold});
        end
    endtask

    task automatic test_basic();
        run_refill("basic", 20'h12345, IW'(5), 2'd2, WOW'(3), 2, 16'b1111, 4, 1'b0, 1'b0);
        cyc();
    endtask

    task automatic test_gapped();
        run_refill("gapped", 20'hCAFE1, IW'(17), 2'd1, WOW'(1), 0, 16'b1011001, 7, 1'b0, 1'b0);
        cyc();
    endtask

    task automatic test_crit_word();
        run_refill("crit", 20'h0F00D, IW'(33), 2'd3, WOW'(2), 1, 16'b1111, 4, 1'b0, 1'b0);
        cyc();
    endtask

    task automatic test_early_rvalid();
        run_refill("early", 20'h55AA5, IW'(60), 2'd0, WOW'(1), 3, 16'b11011, 5, 1'b1, 1'b0);
        cyc();
    endtask

    task automatic test_reset_mid_fill();
        int vw;
        vw = valid_writes;
        miss_tag = 20'h0ABCD; miss_index = IW'(9); miss_way = 2'd1; miss_offset = '0;
        miss_valid = 1'b1;
        cyc();
        miss_valid = 1'b0;
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata = 32'h1111_0000 + 32'(i);
            cyc();
        end
        mem_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        test_reset();
        cyc();
        rst = 1'b0;
        n_cmp++;
        if (valid_writes !== vw) begin
            n_err++;
            $display("FAIL rst_no_valid got %0d valid tag writes want %0d", valid_writes, vw);
        end
        run_refill("after_rst", 20'h00777, IW'(9), 2'd1, WOW'(3), 0, 16'b1111, 4, 1'b0, 1'b0);
        cyc();
    endtask

    task automatic test_back_to_back();
        run_refill("b2b_a", 20'hB2B01, IW'(12), 2'd2, WOW'(0), 1, 16'b1111, 4, 1'b0, 1'b1);
        run_refill("b2b_b", 20'hB2B01, IW'(12), 2'd2, WOW'(0), 0, 16'b1111, 4, 1'b0, 1'b0);
        cyc();
    endtask

    initial begin
        rst = 1'b1; miss_valid = 1'b0; miss_tag = '0; miss_index = '0; miss_offset = '0; miss_way = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #3;
        test_reset();
        cyc();
        rst = 1'b0;
        test_basic();
        test_gapped();
        test_crit_word();
        test_early_rvalid();
        test_reset_mid_fill();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
